// File: rtl/core_zero_padding_pkg.sv
// Shared types and sizing helpers for the zero-padding stage.
// Holds the padding FSM encoding, the pad/interior position class used by the
// downstream conv line-buffer stages, the stage-1 pipeline payload, and the
// default output geometry with its derived counter widths.
package core_zero_padding_pkg;

    localparam int unsigned ZP_DWIDTH = 32;
    localparam int unsigned ZP_WIDTH  = 56;
    localparam int unsigned ZP_HEIGHT = 56;
    localparam int unsigned ZP_PAD    = 1;

    // Padded output geometry for the default configuration.
    localparam int unsigned OW = ZP_WIDTH + 2 * ZP_PAD;
    localparam int unsigned OH = ZP_HEIGHT + 2 * ZP_PAD;

    // Counter width able to hold 0..n-1 (never below 1 bit).
    function automatic int unsigned zp_cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned COL_W = zp_cnt_width(OW);
    localparam int unsigned ROW_W = zp_cnt_width(OH);

    typedef enum logic [2:0] {
        PAD_TOP    = 3'd0,
        ROW_LEFT   = 3'd1,
        ROW_DATA   = 3'd2,
        ROW_RIGHT  = 3'd3,
        PAD_BOTTOM = 3'd4
    } zp_state_e;

    typedef enum logic {
        POS_INTERIOR = 1'b0,
        POS_PAD      = 1'b1
    } zp_pos_class_e;

    // Decision carried from stage 0 into the cycle where read data is valid.
    typedef struct packed {
        logic          valid;
        zp_pos_class_e pos_class;
        logic          last;
    } zp_stage_t;

endpackage

// File: rtl/zp_position_counter.sv
// Raster position tracker for the zero-padding stage.
// Ports:
//   clock, reset  - clock, asynchronous active-high reset
//   advance       - consume the current position this cycle
//   is_pad        - current position is a border (zero) position
//   last_pos      - current position is (OH-1, OW-1)
module zp_position_counter
    import core_zero_padding_pkg::*;
#(
    parameter int unsigned WIDTH  = ZP_WIDTH,
    parameter int unsigned HEIGHT = ZP_HEIGHT,
    parameter int unsigned PAD    = ZP_PAD
) (
    input  logic clock,
    input  logic reset,
    input  logic advance,
    output logic is_pad,
    output logic last_pos
);

    localparam int unsigned P_OW = WIDTH + 2 * PAD;
    localparam int unsigned P_OH = HEIGHT + 2 * PAD;
    localparam int unsigned CW   = zp_cnt_width(P_OW);
    localparam int unsigned RW   = zp_cnt_width(P_OH);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    zp_state_e     state_q;
    zp_state_e     state_d;

    assign col_last = (col == CW'(P_OW - 1));
    assign row_last = (row == RW'(P_OH - 1));

    // Raster col/row counters; hold whenever the position is not consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= PAD_TOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: each region ends on the column/row where it is consumed.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            case (state_q)
                PAD_TOP:    if (col_last && row == RW'(PAD - 1)) state_d = ROW_LEFT;
                ROW_LEFT:   if (col == CW'(PAD - 1)) state_d = ROW_DATA;
                ROW_DATA:   if (col == CW'(PAD + WIDTH - 1)) state_d = ROW_RIGHT;
                ROW_RIGHT:  if (col_last) state_d = (row == RW'(PAD + HEIGHT - 1)) ? PAD_BOTTOM : ROW_LEFT;
                PAD_BOTTOM: if (col_last && row_last) state_d = PAD_TOP;
                default:    state_d = PAD_TOP;
            endcase
        end
    end

    assign is_pad   = (state_q != ROW_DATA);
    assign last_pos = (state_q == PAD_BOTTOM) && col_last && row_last;

endmodule

// File: rtl/core_zero_padding.sv
// Zero-padding stage between the max-pool output FIFO and the next conv
// layer's line buffer. Reads WIDTH x HEIGHT words in raster order and writes
// (WIDTH+2*PAD) x (HEIGHT+2*PAD) words, border words forced to zero.
// Optional status outputs are enabled by defining CORE_ZERO_PADDING_STATUS_EN.
// Ports:
//   clock, reset   - clock, asynchronous active-high reset
//   ff_rdata       - read-FIFO data, valid the cycle after ff_rdreq
//   ff_rdreq       - read-FIFO pop (combinational decode of stage 0)
//   ff_empty       - read-FIFO empty
//   ff_wdata       - write-FIFO data (holds when ff_wrreq is low)
//   ff_wrreq       - write-FIFO push
//   ff_full        - write-FIFO almost-full (>= 3 entries of slack)
//   frame_done     - (status) pulse with the write of the last position
//   frame_count    - (status) completed frame counter, wraps at 16 bits
module core_zero_padding
    import core_zero_padding_pkg::*;
#(
    parameter int unsigned DWIDTH = ZP_DWIDTH,
    parameter int unsigned WIDTH  = ZP_WIDTH,
    parameter int unsigned HEIGHT = ZP_HEIGHT,
    parameter int unsigned PAD    = ZP_PAD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] ff_rdata,
    output logic              ff_rdreq,
    input  logic              ff_empty,
    output logic [DWIDTH-1:0] ff_wdata,
    output logic              ff_wrreq,
    input  logic              ff_full
`ifdef CORE_ZERO_PADDING_STATUS_EN
    ,
    output logic              frame_done,
    output logic [15:0]       frame_count
`endif
);

    logic      is_pad;
    logic      last_pos;
    logic      advance_c;
    zp_stage_t stage1;

    // Pad positions need only write space; interior ones also need a word.
    assign advance_c = ~ff_full & (is_pad | ~ff_empty);
    assign ff_rdreq  = advance_c & ~is_pad;

    zp_position_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .PAD    (PAD)
    ) u_position (
        .clock    (clock),
        .reset    (reset),
        .advance  (advance_c),
        .is_pad   (is_pad),
        .last_pos (last_pos)
    );

    // Two-stage pipeline: equal latency for pad and interior keeps raster order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage1   <= '0;
            ff_wrreq <= 1'b0;
            ff_wdata <= '0;
        end else begin
            stage1.valid     <= advance_c;
            stage1.pos_class <= is_pad ? POS_PAD : POS_INTERIOR;
            stage1.last      <= last_pos;
            ff_wrreq         <= stage1.valid;
            if (stage1.valid) begin
                ff_wdata <= (stage1.pos_class == POS_PAD) ? '0 : ff_rdata;
            end
        end
    end

`ifdef CORE_ZERO_PADDING_STATUS_EN
    // Frame status, aligned with the write of the final position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= stage1.valid & stage1.last;
            if (stage1.valid && stage1.last) begin
                frame_count <= frame_count + 16'(1);
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = stage1.last;
`endif

endmodule

// File: tb/tb_core_zero_padding.sv
// Self-checking bench for core_zero_padding: a 4x3 PAD=1 instance and a
// 2x2 PAD=3 instance, each fed by a normal-mode read FIFO model. Expected
// output words are queued from an independent raster model and compared
// against the observed write stream.
module tb_core_zero_padding;

    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] ff_rdata = '0;
    logic          ff_rdreq;
    logic          ff_empty = 1'b1;
    logic [DW-1:0] ff_wdata;
    logic          ff_wrreq;
    logic          ff_full = 1'b0;

    logic [DW-1:0] p3_rdata = '0;
    logic          p3_rdreq;
    logic          p3_empty = 1'b1;
    logic [DW-1:0] p3_wdata;
    logic          p3_wrreq;
    logic          p3_full = 1'b0;

`ifdef CORE_ZERO_PADDING_STATUS_EN
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          p3_frame_done;
    logic [15:0]   p3_frame_count;
`endif

    always #5 clock = ~clock;

    core_zero_padding #(.DWIDTH(DW), .WIDTH(4), .HEIGHT(3), .PAD(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .ff_rdata (ff_rdata),
        .ff_rdreq (ff_rdreq),
        .ff_empty (ff_empty),
        .ff_wdata (ff_wdata),
        .ff_wrreq (ff_wrreq),
        .ff_full  (ff_full)
`ifdef CORE_ZERO_PADDING_STATUS_EN
        ,
        .frame_done  (frame_done),
        .frame_count (frame_count)
`endif
    );

    core_zero_padding #(.DWIDTH(DW), .WIDTH(2), .HEIGHT(2), .PAD(3)) dut_p3 (
        .clock    (clock),
        .reset    (reset),
        .ff_rdata (p3_rdata),
        .ff_rdreq (p3_rdreq),
        .ff_empty (p3_empty),
        .ff_wdata (p3_wdata),
        .ff_wrreq (p3_wrreq),
        .ff_full  (p3_full)
`ifdef CORE_ZERO_PADDING_STATUS_EN
        ,
        .frame_done  (p3_frame_done),
        .frame_count (p3_frame_count)
`endif
    );

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] src2_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp2_q[$];
    logic [DW-1:0] obs_q[$];
    logic [DW-1:0] obs2_q[$];
    int            obs_cyc[$];
    int            obs2_cyc[$];
    bit            full_hist[int];
    logic [DW-1:0] pop_w;
    logic [DW-1:0] pop2_w;

    int cyc = 0;
    int c0 = 0;
    int full_mode = 0;
    int rd_pulses = 0;
    int empty_viol = 0;
    int full_viol = 0;
    int done_pulses = 0;
    int done_viol = 0;
    int checks = 0;
    int passed = 0;

    // Normal-mode read FIFO models: data one cycle after the pop, empty registered.
    always @(posedge clock) begin
        if (ff_rdreq && src_q.size() > 0) begin
            pop_w = src_q.pop_front();
            ff_rdata <= pop_w;
        end
        ff_empty <= (src_q.size() == 0);
        if (p3_rdreq && src2_q.size() > 0) begin
            pop2_w = src2_q.pop_front();
            p3_rdata <= pop2_w;
        end
        p3_empty <= (src2_q.size() == 0);
    end

    // One cycle: drive ff_full for the cycle, then sample outputs mid-cycle.
    task automatic step();
        @(negedge clock);
        cyc++;
        ff_full = (full_mode == 1) ? ((cyc % 3) == 0) : 1'b0;
        full_hist[cyc] = ff_full;
        #1;
        if (ff_rdreq) rd_pulses++;
        if (ff_rdreq && ff_empty) empty_viol++;
        if (ff_wrreq) begin
            obs_q.push_back(ff_wdata);
            obs_cyc.push_back(cyc);
            if (full_hist.exists(cyc - 2) && full_hist[cyc - 2]) full_viol++;
        end
        if (p3_wrreq) begin
            obs2_q.push_back(p3_wdata);
            obs2_cyc.push_back(cyc);
        end
`ifdef CORE_ZERO_PADDING_STATUS_EN
        if (frame_done) begin
            done_pulses++;
            if (!ff_wrreq || (obs_q.size() % 30) != 0) done_viol++;
        end
`endif
    endtask

    // Raster model of one padded frame; interior words are base+1, base+2, ...
    task automatic build_frame(input int w, input int h, input int p, input int base, input bit second);
        logic [DW-1:0] v;
        for (int r = 0; r < h + 2 * p; r++) begin
            for (int c = 0; c < w + 2 * p; c++) begin
                if (r >= p && r < p + h && c >= p && c < p + w)
                    v = DW'(base + (r - p) * w + (c - p) + 1);
                else
                    v = '0;
                if (second) exp2_q.push_back(v);
                else        exp_q.push_back(v);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        full_mode = 0;
        src_q.delete();
        src2_q.delete();
        exp_q.delete();
        exp2_q.delete();
        obs_q.delete();
        obs2_q.delete();
        obs_cyc.delete();
        obs2_cyc.delete();
        rd_pulses = 0;
        empty_viol = 0;
        full_viol = 0;
        done_pulses = 0;
        done_viol = 0;
        repeat (3) step();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        c0 = cyc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ff_wrreq !== 1'b0) $display("FAIL reset_wrreq: got %b want 0", ff_wrreq); else passed++;
        checks++;
        if (ff_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", ff_wdata); else passed++;
        checks++;
        if (ff_rdreq !== 1'b0) $display("FAIL reset_rdreq: got %b want 0", ff_rdreq); else passed++;
        checks++;
        if (p3_wrreq !== 1'b0) $display("FAIL reset_p3_wrreq: got %b want 0", p3_wrreq); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 12; i++) src_q.push_back(DW'(i));
        build_frame(4, 3, 1, 0, 1'b0);
        repeat (2) step();
        release_reset();
        repeat (31) step();
        checks++;
        if (obs_q.size() !== 30) $display("FAIL basic_count: got %0d want 30", obs_q.size()); else passed++;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (i >= obs_q.size()) $display("FAIL basic_word[%0d]: missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL basic_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (obs_cyc.size() == 0 || obs_cyc[0] !== c0 + 2)
            $display("FAIL basic_latency: first write at %0d want %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, c0 + 2);
        else passed++;
        checks++;
        if (obs_cyc.size() < 30 || (obs_cyc[29] - obs_cyc[0]) !== 29)
            $display("FAIL basic_consecutive: span %0d want 29", (obs_cyc.size() >= 30) ? obs_cyc[29] - obs_cyc[0] : -1);
        else passed++;
        checks++;
        if (rd_pulses !== 12) $display("FAIL basic_rdreq_count: got %0d want 12", rd_pulses); else passed++;
    endtask

    task automatic test_empty_start();
        do_reset();
        build_frame(4, 3, 1, 0, 1'b0);
        release_reset();
        repeat (20) step();
        checks++;
        if (obs_q.size() !== 7) $display("FAIL empty_stall_count: got %0d want 7", obs_q.size()); else passed++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= obs_q.size()) $display("FAIL empty_zero[%0d]: missing want 0", i);
            else if (obs_q[i] !== '0) $display("FAIL empty_zero[%0d]: got %h want 0", i, obs_q[i]);
            else passed++;
        end
        checks++;
        if (rd_pulses !== 0 || ff_rdreq !== 1'b0) $display("FAIL empty_no_rdreq: pulses %0d rdreq %b want 0", rd_pulses, ff_rdreq); else passed++;
        src_q.push_back(DW'(1));
        repeat (6) step();
        checks++;
        if (obs_q.size() !== 8) $display("FAIL empty_resume_count: got %0d want 8", obs_q.size()); else passed++;
        checks++;
        if (obs_q.size() < 8 || obs_q[7] !== DW'(1)) $display("FAIL empty_resume_word: got %h want 1", (obs_q.size() >= 8) ? obs_q[7] : '1); else passed++;
        for (int i = 2; i <= 12; i++) src_q.push_back(DW'(i));
        repeat (30) step();
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (i >= obs_q.size()) $display("FAIL empty_word[%0d]: missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL empty_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (empty_viol !== 0) $display("FAIL empty_rdreq_while_empty: got %0d want 0", empty_viol); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 1; i <= 24; i++) src_q.push_back(DW'(i));
        build_frame(4, 3, 1, 0, 1'b0);
        build_frame(4, 3, 1, 12, 1'b0);
        full_mode = 1;
        repeat (2) step();
        release_reset();
        for (int i = 0; i < 400 && obs_q.size() < 60; i++) step();
        full_mode = 0;
        checks++;
        if (obs_q.size() < 60) $display("FAIL bp_timeout: got %0d writes want 60", obs_q.size()); else passed++;
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (i >= obs_q.size()) $display("FAIL bp_word[%0d]: missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL bp_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (full_viol !== 0) $display("FAIL bp_write_after_full: got %0d want 0", full_viol); else passed++;
        checks++;
        if (empty_viol !== 0) $display("FAIL bp_rdreq_while_empty: got %0d want 0", empty_viol); else passed++;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 1; i <= 12; i++) src_q.push_back(DW'(i));
        repeat (2) step();
        release_reset();
        repeat (15) step();
        reset = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (ff_wrreq !== 1'b0 || ff_wdata !== '0 || ff_rdreq !== 1'b0)
                $display("FAIL midreset_outputs: wrreq %b wdata %h rdreq %b want 0", ff_wrreq, ff_wdata, ff_rdreq);
            else passed++;
        end
        do_reset();
        for (int i = 1; i <= 12; i++) src_q.push_back(DW'(i));
        build_frame(4, 3, 1, 0, 1'b0);
        repeat (2) step();
        release_reset();
        repeat (31) step();
        checks++;
        if (obs_q.size() !== 30) $display("FAIL midreset_count: got %0d want 30", obs_q.size()); else passed++;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (i >= obs_q.size()) $display("FAIL midreset_word[%0d]: missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL midreset_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 8; i++) src2_q.push_back(DW'(100 + i));
        build_frame(2, 2, 3, 100, 1'b1);
        build_frame(2, 2, 3, 104, 1'b1);
        repeat (2) step();
        release_reset();
        for (int i = 0; i < 300 && obs2_q.size() < 128; i++) step();
        checks++;
        if (obs2_q.size() < 128) $display("FAIL p3_timeout: got %0d writes want 128", obs2_q.size()); else passed++;
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (i >= obs2_q.size()) $display("FAIL p3_word[%0d]: missing want %h", i, exp2_q[i]);
            else if (obs2_q[i] !== exp2_q[i]) $display("FAIL p3_word[%0d]: got %h want %h", i, obs2_q[i], exp2_q[i]);
            else passed++;
        end
        checks++;
        if (obs2_cyc.size() < 128 || (obs2_cyc[127] - obs2_cyc[0]) !== 127)
            $display("FAIL p3_no_idle: span %0d want 127", (obs2_cyc.size() >= 128) ? obs2_cyc[127] - obs2_cyc[0] : -1);
        else passed++;
    endtask

`ifdef CORE_ZERO_PADDING_STATUS_EN
    task automatic test_status();
        do_reset();
        for (int i = 1; i <= 36; i++) src_q.push_back(DW'(i));
        repeat (2) step();
        release_reset();
        for (int i = 0; i < 300 && obs_q.size() < 90; i++) step();
        checks++;
        if (done_pulses !== 3) $display("FAIL status_done_pulses: got %0d want 3", done_pulses); else passed++;
        checks++;
        if (done_viol !== 0) $display("FAIL status_done_align: got %0d misaligned want 0", done_viol); else passed++;
        checks++;
        if (frame_count !== 16'd3) $display("FAIL status_frame_count: got %0d want 3", frame_count); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty_start();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
`ifdef CORE_ZERO_PADDING_STATUS_EN
        test_status();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
